// File: rtl/alu_iter.sv
// alu_iter: handshaked execution unit with registered outputs.
// Single-cycle logic/arith/shift/branch ops plus an iterative shift-add
// multiplier and, when ALU_ITER_DIV_EN is defined, a restoring divider.
// Without ALU_ITER_DIV_EN, DIVU/REMU decode as illegal ops.
module alu_iter #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [4:0]       op_i,
  input  logic [WIDTH-1:0] rd_i,
  input  logic [WIDTH-1:0] rs_i,
  output logic             valid_o,
  input  logic             yumi_i,
  output logic [WIDTH-1:0] result_o,
  output logic             jump_now_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADDU  = 5'd0,  OP_SUBU = 5'd1,  OP_SLLV = 5'd2,  OP_SRAV = 5'd3,
    OP_SRLV  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6,  OP_NOR  = 5'd7,
    OP_SLT   = 5'd8,  OP_SLTU = 5'd9,  OP_ROL  = 5'd10, OP_BEQZ = 5'd11,
    OP_BNEZ  = 5'd12, OP_BGTZ = 5'd13, OP_BLTZ = 5'd14, OP_PASSB = 5'd15,
    OP_PASSA = 5'd16, OP_MULU = 5'd17, OP_DIVU = 5'd18, OP_REMU = 5'd19
  } op_e;

  state_e             state;
  op_e                op_dec;
  op_e                op_q;
  logic [SHAMT_W-1:0] cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   opa;
  logic [WIDTH-1:0]   opb;

  logic [WIDTH-1:0]   simple_res;
  logic               simple_jmp;
  logic               is_iter;
  logic [SHAMT_W-1:0] shamt;
  logic [SHAMT_W-1:0] rol_idx;
  logic [WIDTH-1:0]   mul_acc_next;
  logic               last_step;

  assign op_dec    = op_e'(op_i);
  assign shamt     = rs_i[SHAMT_W-1:0];
  assign ready_o   = (state == S_IDLE) && !reset;
  assign last_step = (cnt == SHAMT_W'(WIDTH - 1));

  // multiplier step: add shifted multiplicand when the current multiplier bit is set
  assign mul_acc_next = opb[0] ? (acc + opa) : acc;

`ifdef ALU_ITER_DIV_EN
  logic [WIDTH-1:0] div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_next;
  logic [WIDTH-1:0] div_quo_next;

  // restoring divide step; acc[WIDTH-1] is the carry-out of the shifted
  // partial remainder, so the trial subtract never needs a WIDTH+1 datapath
  assign div_sh       = {acc[WIDTH-2:0], opa[WIDTH-1]};
  assign div_ge       = acc[WIDTH-1] | (div_sh >= opb);
  assign div_rem_next = div_ge ? (div_sh - opb) : div_sh;
  assign div_quo_next = {opa[WIDTH-2:0], div_ge};

  assign is_iter = (op_dec == OP_MULU) || (op_dec == OP_DIVU) || (op_dec == OP_REMU);
`else
  assign is_iter = (op_dec == OP_MULU);
`endif

  // single-cycle result and branch decision; anything undecoded yields zeros
  always_comb begin
    simple_res = '0;
    simple_jmp = 1'b0;
    rol_idx    = '0;
    case (op_dec)
      OP_ADDU:  simple_res = rd_i + rs_i;
      OP_SUBU:  simple_res = rd_i - rs_i;
      OP_SLLV:  simple_res = rd_i << shamt;
      OP_SRAV:  simple_res = $unsigned($signed(rd_i) >>> shamt);
      OP_SRLV:  simple_res = rd_i >> shamt;
      OP_AND:   simple_res = rd_i & rs_i;
      OP_OR:    simple_res = rd_i | rs_i;
      OP_NOR:   simple_res = ~(rd_i | rs_i);
      OP_SLT:   simple_res = {{(WIDTH-1){1'b0}}, ($signed(rd_i) < $signed(rs_i))};
      OP_SLTU:  simple_res = {{(WIDTH-1){1'b0}}, (rd_i < rs_i)};
      OP_ROL: begin
        // modular bit-index rotate: an amount of zero maps every bit to itself
        for (int unsigned i = 0; i < WIDTH; i++) begin
          rol_idx       = SHAMT_W'(i) - shamt;
          simple_res[i] = rd_i[rol_idx];
        end
      end
      OP_BEQZ:  simple_jmp = (rd_i == '0);
      OP_BNEZ:  simple_jmp = (rd_i != '0);
      OP_BGTZ:  simple_jmp = !rd_i[WIDTH-1] && (rd_i != '0);
      OP_BLTZ:  simple_jmp = rd_i[WIDTH-1];
      OP_PASSB: simple_res = rs_i;
      OP_PASSA: simple_res = rd_i;
      default:  simple_res = '0;
    endcase
  end

  // control FSM, iterative datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      valid_o    <= 1'b0;
      result_o   <= '0;
      jump_now_o <= 1'b0;
      cnt        <= '0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      op_q       <= OP_ADDU;
    end else begin
      case (state)
        S_IDLE: begin
          if (valid_i) begin
            if (is_iter) begin
              op_q  <= op_dec;
              acc   <= '0;
              opa   <= rd_i;
              opb   <= rs_i;
              cnt   <= '0;
              state <= S_BUSY;
            end else begin
              result_o   <= simple_res;
              jump_now_o <= simple_jmp;
              valid_o    <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          cnt <= cnt + SHAMT_W'(1);
`ifdef ALU_ITER_DIV_EN
          if (op_q != OP_MULU) begin
            acc <= div_rem_next;
            opa <= div_quo_next;
            if (last_step) begin
              result_o   <= (op_q == OP_DIVU) ? div_quo_next : div_rem_next;
              jump_now_o <= 1'b0;
              valid_o    <= 1'b1;
              state      <= S_DONE;
            end
          end else
`endif
          begin
            acc <= mul_acc_next;
            opa <= opa << 1;
            opb <= opb >> 1;
            if (last_step) begin
              result_o   <= mul_acc_next;
              jump_now_o <= 1'b0;
              valid_o    <= 1'b1;
              state      <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (yumi_i) begin
            valid_o <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_iter.md
# alu_iter

Parametrised, handshaked execution unit for the core's next revision. It replaces the purely combinational ALU with a registered-output unit that:
- adds an iterative unsigned multiply and divide/remainder;
- fixes rotate-by-zero;
- drives defined values on every output for every opcode.

It sits between operand read and writeback. The pipeline stalls on `ready_o`/`valid_o`.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width; must be a power of two, ≥ 8.
- `SHAMT_W`, `$clog2(WIDTH)`: shift/rotate amount width; derived, do not override.

Ports:
- `clk`, in, 1: sole clock; all state updates on rising edge.
- `reset`, in, 1: synchronous, active-high.
- `valid_i`, in, 1: request present.
- `ready_o`, out, 1: unit can accept; request accepted when `valid_i && ready_o`.
- `op_i`, in, 5: opcode, sampled on accept.
- `rd_i`, in, `WIDTH`: operand A, sampled on accept.
- `rs_i`, in, `WIDTH`: operand B, sampled on accept.
- `valid_o`, out, 1: `result_o`/`jump_now_o` valid.
- `yumi_i`, in, 1: consumer takes the result; legal only while `valid_o`=1.
- `result_o`, out, `WIDTH`: registered result.
- `jump_now_o`, out, 1: registered branch decision.

## Operation
Opcodes (`op_i`), with A=`rd_i`, B=`rs_i`:
- 0 ADDU, 1 SUBU: A+B, A−B, modulo 2^WIDTH.
- 2 SLLV, 3 SRAV, 4 SRLV: shift A by B[SHAMT_W-1:0].
- 5 AND, 6 OR, 7 NOR.
- 8 SLT (signed), 9 SLTU: result 1 or 0.
- 10 ROL: rotate A left by B[SHAMT_W-1:0]; amount 0 returns A.
- 11 BEQZ, 12 BNEZ, 13 BGTZ (signed), 14 BLTZ (signed): test A.
- 15 PASSB: result B.
- 16 PASSA: result A.
- 17 MULU: low WIDTH bits of A×B.
- 18 DIVU: A/B.
- 19 REMU: A mod B.
- 20–31: illegal.

Result and branch rules:
- Branch ops: `result_o`=0; `jump_now_o` = test outcome.
- All other ops, including illegal: `jump_now_o`=0.
- Illegal ops: `result_o`=0.
- Divide by zero: quotient = all ones, remainder = A. No trap.

FSM states IDLE, BUSY, DONE:
- **IDLE**: `ready_o`=1.
  - Accept of ops 0–16 or illegal: compute combinationally, register result → DONE.
  - Accept of MULU/DIVU/REMU: load operands, clear accumulator, counter=0 → BUSY.
- **BUSY**: `ready_o`=0. One bit per cycle:
  - MULU: shift-add.
  - DIVU/REMU: restoring divide.
  - When counter = WIDTH−1, register the final result → DONE.
- **DONE**: `valid_o`=1, `ready_o`=0. Outputs hold stable until `yumi_i`; then → IDLE.

Reset:
- Reset values: state IDLE, `valid_o`=0, `result_o`=0, `jump_now_o`=0, counter=0.
- `ready_o`=0 while `reset`=1.
- Reset in BUSY or DONE aborts the operation. No result is ever presented for it.

## Timing
- Latency from accept edge to `valid_o`=1: simple ops 1 cycle; MULU/DIVU/REMU WIDTH+1 cycles (33 at default).
- Throughput without backpressure: simple ops 2 cycles/op (accept, DONE+yumi); iterative ops WIDTH+2 cycles/op.
- There is no same-cycle bypass. In DONE, `ready_o`=0 even if `yumi_i`=1. `ready_o` rises the cycle after `yumi_i`.
- `valid_i` while not ready is ignored; the requester must hold its request.
- `yumi_i` with `valid_o`=0 is ignored.
- Operand changes after accept have no effect.

## Configuration
- `ALU_ITER_DIV_EN` defined: DIVU/REMU as described; divider datapath built.
- `ALU_ITER_DIV_EN` undefined:
  - No divider logic.
  - Ops 18/19 are treated as illegal: 1-cycle latency, `result_o`=0, `jump_now_o`=0.
  - MULU is unaffected.

## Test plan
- Reset, then ADDU A=0xFFFF_FFFF, B=1 → `valid_o` 1 cycle after accept, `result_o`=0, `jump_now_o`=0; after `yumi_i`, `ready_o`=1 next cycle.
- ROL A=0x8000_0001 with B=0, B=1, and B=36 → results 0x8000_0001, 0x0000_0003, 0x0000_0018.
- MULU A=0x0001_0003, B=0x0002_0005 → `valid_o` exactly 33 cycles after accept, result 0x000B_000F; `ready_o`=0 throughout.
- DIVU A=100, B=7 → 14; REMU → 2; DIVU A=5, B=0 → 0xFFFF_FFFF; REMU A=5, B=0 → 5. Without `ALU_ITER_DIV_EN`, DIVU → 0 after 1 cycle.
- BLTZ A=0x8000_0000 → `jump_now_o`=1, `result_o`=0. BGTZ A=0 → `jump_now_o`=0. Hold `yumi_i`=0 for 10 cycles → outputs stable and `ready_o`=0 throughout.
- Assert `reset` at cycle 10 of a MULU → next cycle IDLE, `valid_o`=0, `result_o`=0. A subsequent SUBU 3−5 returns 0xFFFF_FFFE.
